// File: rtl/fp_pkg.sv
// Shared FPU types and constants.
// Single-precision layout, FSM states and the canonical NaN.
package fp_pkg;

    localparam int FP_EXP_W   = 8;
    localparam int FP_MAN_W   = 23;
    localparam int FP_BIAS    = 127;
    localparam int FP_EXP_MAX = 255;

    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

    typedef struct packed {
        logic                s;
        logic [FP_EXP_W-1:0] e;
        logic [FP_MAN_W-1:0] m;
    } fp32_t;

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        ALIGN,
        ADD,
        NORM,
        ROUND,
        DONE
    } fp_state_e;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a normalized {1,m,g,r,s} mantissa.
// Flags exponent overflow so the caller can substitute Inf.
module fp_round_rne
    import fp_pkg::*;
(
    input  logic signed [9:0] exp_i,
    input  logic [26:0]       man_i,
    input  logic              sign_i,
    output fp32_t             res_o,
    output logic              ovf_o
);

    logic               up;
    logic [24:0]        rsum;
    logic signed [9:0]  e_r;

    // Increment on guard when round/sticky set or on an exact tie with odd lsb.
    always_comb begin
        up      = man_i[2] & (man_i[1] | man_i[0] | man_i[3]);
        rsum    = {1'b0, man_i[26:3]} + {24'b0, up};
        e_r     = exp_i + (rsum[24] ? 10'sd1 : 10'sd0);
        ovf_o   = e_r >= 10'(FP_EXP_MAX);
        res_o.s = sign_i;
        res_o.e = e_r[7:0];
        res_o.m = rsum[24] ? rsum[23:1] : rsum[22:0];
    end

endmodule

// File: rtl/fp_addsub_iter.sv
// Iterative single-precision add/subtract, one shift per cycle.
// Handshaked: accepts in IDLE, holds the result in DONE until taken.
module fp_addsub_iter
    import fp_pkg::*;
#(
    parameter int          ALIGN_LIMIT = 26,
    parameter logic [31:0] QNAN        = FP_QNAN
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] c
);

    localparam logic [4:0] LIM5 = 5'(ALIGN_LIMIT);

    fp_state_e         state_q, state_d;
    logic [31:0]       ra_q, ra_d;
    logic [31:0]       rb_q, rb_d;
    logic              sign_q, sign_d;
    logic              sub_q, sub_d;
    logic signed [9:0] exp_q, exp_d;
    logic [27:0]       ma_q, ma_d;
    logic [26:0]       mb_q, mb_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [31:0]       c_q, c_d;

    fp32_t       fa, fb, big, sml;
    logic        swap;
    logic [7:0]  ediff;
    logic [27:0] sum;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    fp32_t       rres;
    logic        rovf;

    // Operand classification, magnitude ordering and the adder datapath.
    always_comb begin
        fa     = ra_q;
        fb     = rb_q;
        a_nan  = (fa.e == 8'hFF) && (fa.m != '0);
        b_nan  = (fb.e == 8'hFF) && (fb.m != '0);
        a_inf  = (fa.e == 8'hFF) && (fa.m == '0);
        b_inf  = (fb.e == 8'hFF) && (fb.m == '0);
        a_zero = fa.e == 8'h00;
        b_zero = fb.e == 8'h00;
        swap   = rb_q[30:0] > ra_q[30:0];
        big    = swap ? fb : fa;
        sml    = swap ? fa : fb;
        ediff  = big.e - sml.e;
        sum    = sub_q ? ma_q - {1'b0, mb_q}
                       : ma_q + {1'b0, mb_q};
    end

    fp_round_rne u_round (
        .exp_i  (exp_q),
        .man_i  (ma_q[26:0]),
        .sign_i (sign_q),
        .res_o  (rres),
        .ovf_o  (rovf)
    );

    // Next-state and datapath update for the align/add/normalize/round FSM.
    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        sign_d  = sign_q;
        sub_d   = sub_q;
        exp_d   = exp_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    ra_d    = a;
                    rb_d    = {b[31] ^ op, b[30:0]};
                    state_d = UNPACK;
                end
            end
            UNPACK: begin
                state_d = DONE;
                if (a_nan || b_nan) begin
                    c_d = QNAN;
                end else if (a_inf && b_inf) begin
                    c_d = (fa.s != fb.s) ? QNAN : ra_q;
                end else if (a_inf) begin
                    c_d = ra_q;
                end else if (b_inf) begin
                    c_d = rb_q;
                end else if (a_zero && b_zero) begin
                    c_d = {fa.s & fb.s, 31'b0};
                end else if (a_zero) begin
                    c_d = rb_q;
                end else if (b_zero) begin
                    c_d = ra_q;
                end else begin
                    sign_d  = big.s;
                    sub_d   = fa.s ^ fb.s;
                    exp_d   = {2'b00, big.e};
                    cnt_d   = (ediff > {3'b0, LIM5}) ? LIM5 : ediff[4:0];
                    ma_d    = {2'b01, big.m, 3'b000};
                    mb_d    = {1'b1, sml.m, 3'b000};
                    state_d = (cnt_d == 5'd0) ? ADD : ALIGN;
                end
            end
            ALIGN: begin
                mb_d  = {1'b0, mb_q[26:2], mb_q[1] | mb_q[0]};
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) state_d = ADD;
            end
            ADD: begin
                // The first left shift of a cancelling difference is folded in here.
                if (sum == '0) begin
                    c_d     = 32'h0;
                    state_d = DONE;
                end else if (sum[27]) begin
                    ma_d    = sum;
                    state_d = NORM;
                end else if (sum[26]) begin
                    ma_d    = sum;
                    state_d = ROUND;
                end else if (exp_q <= 10'sd1) begin
                    c_d     = {sign_q, 31'b0};
                    state_d = DONE;
                end else begin
                    ma_d    = sum << 1;
                    exp_d   = exp_q - 10'sd1;
                    state_d = sum[25] ? ROUND : NORM;
                end
            end
            NORM: begin
                if (ma_q[27]) begin
                    ma_d    = {1'b0, ma_q[27:2], ma_q[1] | ma_q[0]};
                    exp_d   = exp_q + 10'sd1;
                    state_d = ROUND;
                end else if (exp_q <= 10'sd1) begin
                    c_d     = {sign_q, 31'b0};
                    state_d = DONE;
                end else begin
                    ma_d    = ma_q << 1;
                    exp_d   = exp_q - 10'sd1;
                    if (ma_q[25]) state_d = ROUND;
                end
            end
            ROUND: begin
                c_d     = rovf ? {sign_q, 8'hFF, 23'b0} : rres;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            sign_q  <= 1'b0;
            sub_q   <= 1'b0;
            exp_q   <= '0;
            ma_q    <= '0;
            mb_q    <= '0;
            cnt_q   <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            sign_q  <= sign_d;
            sub_q   <= sub_d;
            exp_q   <= exp_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
        end
    end

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign c         = c_q;

endmodule

// File: tb/tb_fp_addsub_iter.sv
// Bench for fp_addsub_iter.
// Scoreboard of expected results and latencies, checked at the output.
module tb_fp_addsub_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        op = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] c;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] c;
        int          lat;
    } exp_t;

    exp_t sb[$];

    fp_addsub_iter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        for (int i = 0; i < 100 && !out_valid; i++) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic start(input logic [31:0] ta, input logic [31:0] tb_,
                         input logic top);
        @(negedge clk);
        a        = ta;
        b        = tb_;
        op       = top;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_op(input string tag, input logic [31:0] ta,
                         input logic [31:0] tb_, input logic top,
                         input logic [31:0] ec, input int elat);
        exp_t e;
        int   lat;
        check({tag, "_rdy"}, 32'(in_ready), 32'd1);
        start(ta, tb_, top);
        e.c   = ec;
        e.lat = elat;
        sb.push_back(e);
        wait_out(lat);
        check({tag, "_vld"}, 32'(out_valid), 32'd1);
        e = sb.pop_front();
        check(tag, c, e.c);
        if (e.lat >= 0) check({tag, "_lat"}, 32'(lat), 32'(e.lat));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        exp_t e;
        int   lat;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_c", c, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        do_op("one_plus_one", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4);
        do_op("neg1_plus_1", 32'hBF800000, 32'h3F800000, 1'b0, 32'h00000000, -1);
        do_op("neg1_minus_1", 32'hBF800000, 32'h3F800000, 1'b1, 32'hC0000000, 4);
        do_op("tie_even", 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 27);
        do_op("ulp_add", 32'h3F800000, 32'h34000000, 1'b0, 32'h3F800001, 26);
        do_op("sticky_only", 32'h3F800000, 32'h30800000, 1'b0, 32'h3F800000, 29);
        do_op("inf_minus_inf", 32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 1);
        do_op("inf_plus_1", 32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 1);
        do_op("overflow", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4);
        do_op("cancel", 32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, 25);
        do_op("pz_plus_nz", 32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 1);
        do_op("nan_in", 32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 1);
        do_op("zero_minus_1", 32'h00000000, 32'h3F800000, 1'b1, 32'hBF800000, 1);
        do_op("three_minus_1", 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4);

        start(32'h3F800000, 32'h3F800000, 1'b0);
        e.c   = 32'h40000000;
        e.lat = 4;
        sb.push_back(e);
        wait_out(lat);
        check("bp_vld", 32'(out_valid), 32'd1);
        e = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a        = 32'h40400000;
            b        = 32'h3F800000;
            in_valid = 1'b1;
            check("bp_hold_vld", 32'(out_valid), 32'd1);
            check("bp_hold_c", c, e.c);
            check("bp_hold_rdy", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_rel_vld", 32'(out_valid), 32'd0);
        check("bp_rel_rdy", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        check("bp_no_accept", 32'(in_ready), 32'd1);

        start(32'h3F800000, 32'h30800000, 1'b0);
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_vld", 32'(out_valid), 32'd0);
        check("abort_rdy", 32'(in_ready), 32'd1);
        check("abort_c", c, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        do_op("after_abort", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
